cpu_controller: RTL and testbench

Instruction-sequencing control unit for the 16-bit CPU datapath. It fetches instructions from the instruction ROM, decodes them, and drives the control inputs of the downstream 16×16 register file, data memory, RF write-data mux and ALU. It owns the program counter (PC) and instruction register (IR) and sequences each instruction through a Moore state machine.

---
 rtl/cpu_controller.sv | 147 ++++++++++++++
 tb/tb_cpu_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - fetch/decode/execute sequencer for the 16-bit CPU datapath
module cpu_controller #(
    parameter int PC_WIDTH = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         ROM_data,
    output logic [PC_WIDTH-1:0] PC_addr,
    output logic [15:0]         IR_out,
    output logic [7:0]          D_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic [3:0]          RF_W_addr,
    output logic                RF_W_en,
    output logic [3:0]          RF_Ra_addr,
    output logic [3:0]          RF_Rb_addr,
    output logic [2:0]          ALU_s0,
    output logic [3:0]          state_out,
    output logic                halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_ir;

    // State register; reset forces INIT immediately so Moore outputs drop at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the instruction and advance the PC only on the edge leaving FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
            r_ir <= '0;
        end else if (r_state == S_FETCH) begin
            r_ir <= ROM_data;
            r_pc <= r_pc + 1'b1;
        end
    end

    // Next-state selection; unused opcodes fall through to NOOP
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (r_ir[15:12])
                    OP_STORE: w_next = S_STORE;
                    OP_LOAD:  w_next = S_LOAD_A;
                    OP_ADD:   w_next = S_ADD;
                    OP_SUB:   w_next = S_SUB;
                    OP_HALT:  w_next = S_HALT;
                    default:  w_next = S_NOOP;
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    // Moore outputs decoded from state and IR fields; anything not driven stays 0
    always_comb begin
        D_addr     = 8'h00;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'h0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'h0;
        RF_Rb_addr = 4'h0;
        ALU_s0     = 3'b000;
        halted     = 1'b0;
        case (r_state)
            S_STORE: begin
                RF_Ra_addr = r_ir[11:8];
                D_addr     = r_ir[7:0];
                D_wr       = 1'b1;
            end
            S_LOAD_A: begin
                // Address presented a cycle early so synchronous memory data is ready in LOAD_B
                D_addr = r_ir[11:4];
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_addr    = r_ir[11:4];
                RF_s      = 1'b1;
                RF_W_addr = r_ir[3:0];
                RF_W_en   = 1'b1;
            end
            S_ADD: begin
                RF_Ra_addr = r_ir[11:8];
                RF_Rb_addr = r_ir[7:4];
                RF_W_addr  = r_ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = 3'b001;
            end
            S_SUB: begin
                RF_Ra_addr = r_ir[11:8];
                RF_Rb_addr = r_ir[7:4];
                RF_W_addr  = r_ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = 3'b010;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign PC_addr   = r_pc;
    assign IR_out    = r_ir;
    assign state_out = r_state;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized instruction-level checks of cpu_controller
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ROM_data;
    logic [6:0]  PC_addr;
    logic [15:0] IR_out;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  state_out;
    logic        halted;

    logic [15:0] rom [0:127];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [15:0] ir;
    } rec_t;

    rec_t        q[$];
    logic [6:0]  m_pc;
    logic [15:0] m_ir;
    bit          m_halt;

    cpu_controller #(.PC_WIDTH(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .ROM_data   (ROM_data),
        .PC_addr    (PC_addr),
        .IR_out     (IR_out),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .state_out  (state_out),
        .halted     (halted)
    );

    assign ROM_data = rom[PC_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(logic [3:0] st, logic [6:0] pc, logic [15:0] ir,
                                       logic [7:0] da, logic dw, logic rs, logic [3:0] wa,
                                       logic we, logic [3:0] ra, logic [3:0] rb,
                                       logic [2:0] alu, logic h);
        return {10'b0, st, pc, ir, da, dw, rs, wa, we, ra, rb, alu, h};
    endfunction

    function automatic logic [63:0] observed();
        return pk(state_out, PC_addr, IR_out, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                  RF_Ra_addr, RF_Rb_addr, ALU_s0, halted);
    endfunction

    // Expected outputs from the instruction table: what each execution step drives
    function automatic logic [63:0] expected(rec_t r);
        logic [15:0] i;
        i = r.ir;
        case (r.st)
            4'd6: return pk(r.st, r.pc, i, i[7:0], 1'b1, 1'b0, 4'h0, 1'b0, i[11:8], 4'h0, 3'd0, 1'b0);
            4'd4: return pk(r.st, r.pc, i, i[11:4], 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
            4'd5: return pk(r.st, r.pc, i, i[11:4], 1'b0, 1'b1, i[3:0], 1'b1, 4'h0, 4'h0, 3'd0, 1'b0);
            4'd7: return pk(r.st, r.pc, i, 8'h00, 1'b0, 1'b0, i[3:0], 1'b1, i[11:8], i[7:4], 3'd1, 1'b0);
            4'd8: return pk(r.st, r.pc, i, 8'h00, 1'b0, 1'b0, i[3:0], 1'b1, i[11:8], i[7:4], 3'd2, 1'b0);
            4'd9: return pk(r.st, r.pc, i, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
            default: return pk(r.st, r.pc, i, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        endcase
    endfunction

    // Expand the next instruction at the model PC into its per-cycle step list
    task automatic refill();
        if (m_halt) begin
            q.push_back('{4'd9, m_pc, m_ir});
        end else begin
            q.push_back('{4'd1, m_pc, m_ir});
            m_ir = rom[m_pc];
            m_pc = 7'((int'(m_pc) + 1) % 128);
            q.push_back('{4'd2, m_pc, m_ir});
            case (m_ir[15:12])
                4'h1: q.push_back('{4'd6, m_pc, m_ir});
                4'h2: begin
                    q.push_back('{4'd4, m_pc, m_ir});
                    q.push_back('{4'd5, m_pc, m_ir});
                end
                4'h3: q.push_back('{4'd7, m_pc, m_ir});
                4'h4: q.push_back('{4'd8, m_pc, m_ir});
                4'h5: begin
                    q.push_back('{4'd9, m_pc, m_ir});
                    m_halt = 1'b1;
                end
                default: q.push_back('{4'd3, m_pc, m_ir});
            endcase
        end
    endtask

    // Hold reset, check the cleared outputs, then release just after a rising edge
    task automatic start(input string tag);
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_reset"}, observed(), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_pc   = 7'd0;
        m_ir   = 16'h0;
        m_halt = 1'b0;
        q.delete();
        q.push_back('{4'd0, 7'd0, 16'h0});
    endtask

    task automatic run(input string tag, input int ncyc);
        rec_t r;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (q.size() == 0) refill();
            r = q.pop_front();
            check(tag, observed(), expected(r));
        end
    endtask

    task automatic fill(input logic [15:0] w);
        for (int a = 0; a < 128; a++) rom[a] = w;
    endtask

    logic [15:0] w_rand;
    logic [3:0]  w_op;

    initial begin
        reset = 1'b1;
        fill(16'h0000);

        // Plain NOOP run: INIT, FETCH, DECODE, NOOP, FETCH ...
        start("noop");
        run("noop", 8);

        // LOAD d=1B Rw=5
        fill(16'h0000);
        rom[0] = 16'h21B5;
        start("load");
        run("load", 10);

        // ADD then SUB
        fill(16'h0000);
        rom[0] = 16'h3123;
        rom[1] = 16'h4314;
        start("addsub");
        run("addsub", 10);

        // STORE then HALT; PC must stay at 2
        fill(16'h0000);
        rom[0] = 16'h1740;
        rom[1] = 16'h5000;
        start("halt");
        run("halt", 28);
        check("halt_pc", {57'b0, PC_addr}, 64'd2);

        // PC wrap 127 -> 0 over all-NOOP ROM
        fill(16'h0000);
        start("wrap");
        run("wrap", 1 + 128 * 3 + 6);

        // Reset during ADD: write enable must drop before the next edge
        fill(16'h0000);
        rom[0] = 16'h3123;
        start("midrst");
        run("midrst", 4);
        reset = 1'b1;
        #1;
        check("midrst_wen", {63'b0, RF_W_en}, 64'd0);
        check("midrst_pc", {57'b0, PC_addr}, 64'd0);
        check("midrst_state", {60'b0, state_out}, 64'd0);

        // Random programs
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 128; a++) begin
                w_rand = 16'($urandom);
                w_op   = w_rand[15:12];
                if (w_op == 4'h5 && $urandom_range(0, 15) != 0) w_rand[15:12] = 4'h3;
                rom[a] = w_rand;
            end
            start("rand");
            run("rand", 300);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
